mips_issue_arbiter: RTL and testbench
=====================================

Name: mips_issue_arbiter

Overview:
- Shares one MIPS execution core between two instruction requesters.
- Each requester has its own FIFO. A round-robin scheduler picks one instruction per cycle and drives the core's in_valid and instruction.
- Issued requester IDs are tracked through the core's fixed latency, so each core_out_valid/instruction_fail is routed back to the requester that issued it.
- Sits between the front-end instruction sources and the MIPS core.

Parameters:
- DEPTH, 4, entries per requester FIFO; power of 2, minimum 2.
- LAT, 2, cycles from core_in_valid high to the matching core_out_valid high.
- CNT_W, 8, width of the per-requester saturating fail counters.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 offers an instruction
- req0_instr  in  32  requester 0 instruction
- req0_ready  out  1  requester 0 FIFO can accept
- req1_valid  in  1  requester 1 offers an instruction
- req1_instr  in  32  requester 1 instruction
- req1_ready  out  1  requester 1 FIFO can accept
- issue_en  in  1  1 = issuing allowed this cycle
- flush  in  1  synchronous clear of both FIFOs
- core_in_valid  out  1  drives the core's in_valid
- core_instruction  out  32  drives the core's instruction
- core_out_valid  in  1  from the core's out_valid
- core_instruction_fail  in  1  from the core's instruction_fail
- rsp0_valid  out  1  one result for requester 0
- rsp0_fail  out  1  that result failed decode
- rsp1_valid  out  1  one result for requester 1
- rsp1_fail  out  1  that result failed decode
- fail_cnt0  out  CNT_W  saturating count of requester 0 failures
- fail_cnt1  out  CNT_W  saturating count of requester 1 failures
- tag_err  out  1  sticky: core returned a result with no pending tag

Behaviour:
Reset:
- All outputs are 0 except req0_ready=1 and req1_ready=1.
- FIFOs are empty, the RR pointer points at requester 0, and the tag pipeline is cleared.

FIFOs:
- reqN_ready = !fullN. Readiness depends only on full, so a full FIFO refuses a push even in a cycle where it pops.
- Push happens on reqN_valid && reqN_ready.
- Pointers are log2(DEPTH)+1 bits wide and wrap naturally.
- There is no same-cycle pass-through: an entry accepted at edge E is first eligible for issue in the cycle after E.

Scheduler:
- Runs each cycle when issue_en=1 and flush=0.
- Candidates are the non-empty FIFOs.
  - One candidate: grant it.
  - Both candidates: grant the requester not granted last; the RR pointer updates only on a grant.
- The grant pops the head. On the next edge, core_in_valid<=1 and core_instruction<=head.
- No grant: core_in_valid<=0 and core_instruction holds its previous value.
- Issue rate is up to one instruction per cycle, back-to-back.

Latency:
- Accept in cycle 0 -> core_in_valid in cycle 2 -> core_out_valid in cycle 2+LAT -> rspN_valid in cycle 3+LAT.

Tag pipeline:
- LAT-stage shift register of {valid, id}, loaded from the registered issue each cycle.
- On core_out_valid=1 with the final-stage valid=1: on the next edge, rsp[id]_valid<=1, rsp[id]_fail<=core_instruction_fail, and the other rsp is 0.
- On core_out_valid=1 with the final-stage valid=0: tag_err<=1; it stays set until reset and no rsp is generated.
- A pending tag with core_out_valid=0 is dropped silently.

Fail counters:
- +1 for each rspN with fail=1.
- Saturate at 2^CNT_W-1.
- Cleared only by reset.

flush:
- Empties both FIFOs at the edge; pushes in the same cycle are discarded.
- Suppresses the grant in that cycle.
- Does not cancel in-flight tags: issued instructions still produce responses.
- The RR pointer is unchanged.

issue_en=0:
- FIFOs keep filling.
- core_in_valid=0 from the next cycle.
- The in-flight tags drain normally.

Async reset mid-operation:
- Immediately returns everything to reset values, including in-flight tags.
- Results returned later by the core raise tag_err only if they arrive after reset is deasserted.

Test Plan:
1. req0 pushes 0x02328020 once, with core_out_valid returned LAT cycles after core_in_valid and fail=0 -> core_instruction=0x02328020 in cycle 2; rsp0_valid=1, rsp0_fail=0 in cycle 5 (LAT=2); rsp1_valid=0.
2. Both FIFOs are preloaded with 3 entries each (A0..A2, B0..B2) while issue_en=0, then issue_en=1 -> core_instruction sequence is A0,B0,A1,B1,A2,B2 on consecutive cycles; responses alternate rsp0/rsp1.
3. Push 5 entries to req0 with issue_en=0 -> req0_ready drops after the 4th accept and the 5th push is refused. Raise issue_en -> ready returns the cycle after the first pop.
4. Issue 3 requester-1 instructions with the core returning fail=1 for each -> rsp1_fail=1 three times, fail_cnt1=3, fail_cnt0=0. With CNT_W=2, five failures -> fail_cnt1 holds at 3.
5. flush with 2 entries queued in req0 and 1 instruction in flight -> the in-flight response still arrives on rsp0, no further core_in_valid, req0_ready=1.
6. Pulse core_out_valid with no prior issue -> tag_err=1 and it remains 1. Async reset mid-stream -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/mips_issue_arbiter_if.sv
// Bundle of requester, core and response signals for mips_issue_arbiter.
// slave = arbiter side, master = environment side (front-ends + core).
`timescale 1ns/1ps
interface mips_issue_arbiter_if #(
   parameter int CNT_W = 8
) ();
   // Valid/ready: a request transfers at a rising edge where reqN_valid and
   // reqN_ready are both 1; ready never depends on valid. Core and rsp
   // strobes are single-cycle with no back-pressure.
   logic             req0_valid;
   logic [31:0]      req0_instr;
   logic             req0_ready;
   logic             req1_valid;
   logic [31:0]      req1_instr;
   logic             req1_ready;
   logic             issue_en;
   logic             flush;
   logic             core_in_valid;
   logic [31:0]      core_instruction;
   logic             core_out_valid;
   logic             core_instruction_fail;
   logic             rsp0_valid;
   logic             rsp0_fail;
   logic             rsp1_valid;
   logic             rsp1_fail;
   logic [CNT_W-1:0] fail_cnt0;
   logic [CNT_W-1:0] fail_cnt1;
   logic             tag_err;

   modport slave (
      input  req0_valid, req0_instr, req1_valid, req1_instr, issue_en, flush,
             core_out_valid, core_instruction_fail,
      output req0_ready, req1_ready, core_in_valid, core_instruction,
             rsp0_valid, rsp0_fail, rsp1_valid, rsp1_fail,
             fail_cnt0, fail_cnt1, tag_err
   );

   modport master (
      output req0_valid, req0_instr, req1_valid, req1_instr, issue_en, flush,
             core_out_valid, core_instruction_fail,
      input  req0_ready, req1_ready, core_in_valid, core_instruction,
             rsp0_valid, rsp0_fail, rsp1_valid, rsp1_fail,
             fail_cnt0, fail_cnt1, tag_err
   );
endinterface

// File: rtl/mips_issue_arbiter.sv
// Two-requester round-robin front end for a fixed-latency MIPS core; routes
// each core result back to the requester that issued it.
`timescale 1ns/1ps
module mips_issue_arbiter #(
   parameter int DEPTH = 4,
   parameter int LAT   = 2,
   parameter int CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   mips_issue_arbiter_if.slave    bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [31:0]      r_mem0 [DEPTH];
   logic [31:0]      r_mem1 [DEPTH];
   logic [PW-1:0]    r_wr0, r_rd0, r_wr1, r_rd1;
   logic             r_rr_ptr;
   logic             r_core_in_valid;
   logic [31:0]      r_core_instr;
   logic             r_issue_id;
   logic [LAT-1:0]   r_tag_v;
   logic [LAT-1:0]   r_tag_id;
   logic             r_rsp0_valid, r_rsp0_fail, r_rsp1_valid, r_rsp1_fail;
   logic [CNT_W-1:0] r_cnt0, r_cnt1;
   logic             r_tag_err;

   logic w_full0, w_full1, w_empty0, w_empty1;
   logic w_push0, w_push1, w_run, w_gnt0, w_gnt1;
   logic w_hit, w_rsp0_set, w_rsp1_set;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign w_full0  = (r_wr0[AW] != r_rd0[AW]) && (r_wr0[AW-1:0] == r_rd0[AW-1:0]);
   assign w_full1  = (r_wr1[AW] != r_rd1[AW]) && (r_wr1[AW-1:0] == r_rd1[AW-1:0]);
   assign w_empty0 = (r_wr0 == r_rd0);
   assign w_empty1 = (r_wr1 == r_rd1);

   assign w_push0 = bus.req0_valid && !w_full0 && !bus.flush;
   assign w_push1 = bus.req1_valid && !w_full1 && !bus.flush;

   // r_rr_ptr names the requester that wins when both are waiting.
   assign w_run  = bus.issue_en && !bus.flush;
   assign w_gnt0 = w_run && !w_empty0 && (w_empty1 || !r_rr_ptr);
   assign w_gnt1 = w_run && !w_empty1 && (w_empty0 ||  r_rr_ptr);

   assign w_hit      = bus.core_out_valid && r_tag_v[LAT-1];
   assign w_rsp0_set = w_hit && !r_tag_id[LAT-1];
   assign w_rsp1_set = w_hit &&  r_tag_id[LAT-1];

   always_ff @(posedge clk) begin
      if (w_push0) r_mem0[r_wr0[AW-1:0]] <= bus.req0_instr;
      if (w_push1) r_mem1[r_wr1[AW-1:0]] <= bus.req1_instr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr0 <= '0;
         r_rd0 <= '0;
         r_wr1 <= '0;
         r_rd1 <= '0;
      end else if (bus.flush) begin
         r_wr0 <= '0;
         r_rd0 <= '0;
         r_wr1 <= '0;
         r_rd1 <= '0;
      end else begin
         if (w_push0) r_wr0 <= r_wr0 + PW'(1);
         if (w_gnt0)  r_rd0 <= r_rd0 + PW'(1);
         if (w_push1) r_wr1 <= r_wr1 + PW'(1);
         if (w_gnt1)  r_rd1 <= r_rd1 + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr        <= 1'b0;
         r_core_in_valid <= 1'b0;
         r_core_instr    <= '0;
         r_issue_id      <= 1'b0;
      end else begin
         r_core_in_valid <= w_gnt0 || w_gnt1;
         if (w_gnt0) begin
            r_rr_ptr     <= 1'b1;
            r_issue_id   <= 1'b0;
            r_core_instr <= r_mem0[r_rd0[AW-1:0]];
         end else if (w_gnt1) begin
            r_rr_ptr     <= 1'b0;
            r_issue_id   <= 1'b1;
            r_core_instr <= r_mem1[r_rd1[AW-1:0]];
         end
      end
   end

   // Tag stage k holds the issue made k+1 cycles earlier; the last stage
   // lines up with the core's out_valid for that issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tag_v  <= '0;
         r_tag_id <= '0;
      end else begin
         r_tag_v[0]  <= r_core_in_valid;
         r_tag_id[0] <= r_issue_id;
         for (int i = 1; i < LAT; i++) begin
            r_tag_v[i]  <= r_tag_v[i-1];
            r_tag_id[i] <= r_tag_id[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp0_valid <= 1'b0;
         r_rsp0_fail  <= 1'b0;
         r_rsp1_valid <= 1'b0;
         r_rsp1_fail  <= 1'b0;
         r_cnt0       <= '0;
         r_cnt1       <= '0;
         r_tag_err    <= 1'b0;
      end else begin
         r_rsp0_valid <= w_rsp0_set;
         r_rsp0_fail  <= w_rsp0_set && bus.core_instruction_fail;
         r_rsp1_valid <= w_rsp1_set;
         r_rsp1_fail  <= w_rsp1_set && bus.core_instruction_fail;
         if (w_rsp0_set && bus.core_instruction_fail && (r_cnt0 != '1))
            r_cnt0 <= r_cnt0 + CNT_W'(1);
         if (w_rsp1_set && bus.core_instruction_fail && (r_cnt1 != '1))
            r_cnt1 <= r_cnt1 + CNT_W'(1);
         if (bus.core_out_valid && !r_tag_v[LAT-1])
            r_tag_err <= 1'b1;
      end
   end

   assign bus.req0_ready       = !w_full0;
   assign bus.req1_ready       = !w_full1;
   assign bus.core_in_valid    = r_core_in_valid;
   assign bus.core_instruction = r_core_instr;
   assign bus.rsp0_valid       = r_rsp0_valid;
   assign bus.rsp0_fail        = r_rsp0_fail;
   assign bus.rsp1_valid       = r_rsp1_valid;
   assign bus.rsp1_fail        = r_rsp1_fail;
   assign bus.fail_cnt0        = r_cnt0;
   assign bus.fail_cnt1        = r_cnt1;
   assign bus.tag_err          = r_tag_err;
endmodule

// File: tb/tb_mips_issue_arbiter.sv
// Directed bench for mips_issue_arbiter with a fixed-latency core model and
// issue/response scoreboards.
`timescale 1ns/1ps
module tb_mips_issue_arbiter;
   localparam int DEPTH = 4;
   localparam int LAT   = 2;
   localparam int CNT_W = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mips_issue_arbiter_if #(.CNT_W(CNT_W)) bus ();

   mips_issue_arbiter #(.DEPTH(DEPTH), .LAT(LAT), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];
   logic [1:0]  rsp_q[$];

   // Core model: out_valid LAT (=2) cycles after in_valid, fail chosen at issue.
   logic cp_v0 = 1'b0, cp_v1 = 1'b0, cp_f0 = 1'b0, cp_f1 = 1'b0;
   logic fail_mode = 1'b0;
   logic stray = 1'b0;
   always @(posedge clk) begin
      cp_v0 <= bus.core_in_valid;
      cp_f0 <= fail_mode;
      cp_v1 <= cp_v0;
      cp_f1 <= cp_f0;
   end
   assign bus.core_out_valid        = cp_v1 | stray;
   assign bus.core_instruction_fail = cp_v1 & cp_f1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ready"}, 32'({bus.req1_ready, bus.req0_ready}), 32'h3);
      check({tag, "_zero"}, 32'({bus.core_in_valid, bus.rsp0_valid, bus.rsp0_fail,
            bus.rsp1_valid, bus.rsp1_fail, bus.tag_err, bus.fail_cnt0, bus.fail_cnt1}), 32'h0);
      check({tag, "_instr"}, bus.core_instruction, 32'h0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req0_instr = '0;
      bus.req1_valid = 1'b0;
      bus.req1_instr = '0;
      bus.issue_en   = 1'b0;
      bus.flush      = 1'b0;
      fail_mode      = 1'b0;
      stray          = 1'b0;
      exp_q.delete();
      rsp_q.delete();
      repeat (4) tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_idle(input string tag, input int max_cycles);
      for (int i = 0; i < max_cycles && (exp_q.size() != 0 || rsp_q.size() != 0); i++)
         tick();
      check(tag, 32'(exp_q.size() + rsp_q.size()), 32'h0);
      repeat (2) tick();
   endtask

   // Scoreboard monitor: every issue and every response must match the queue head.
   always @(negedge clk) begin
      logic [31:0] e_i;
      logic [1:0]  e_r;
      if (rst_n === 1'b1) begin
         if (bus.core_in_valid === 1'b1) begin
            check("issue_expected", 32'(exp_q.size() != 0), 32'h1);
            if (exp_q.size() != 0) begin
               e_i = exp_q.pop_front();
               check("issue_instr", bus.core_instruction, e_i);
            end
         end
         if (bus.rsp0_valid === 1'b1 || bus.rsp1_valid === 1'b1) begin
            check("rsp_expected", 32'(rsp_q.size() != 0), 32'h1);
            if (rsp_q.size() != 0) begin
               e_r = rsp_q.pop_front();
               check("rsp_route", 32'({bus.rsp1_valid, bus.rsp1_fail, bus.rsp0_valid, bus.rsp0_fail}),
                     e_r[1] ? 32'({1'b1, e_r[0], 2'b00}) : 32'({2'b00, 1'b1, e_r[0]}));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      check_reset("reset");

      // 1: single issue, cycle-accurate latency
      bus.issue_en   = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req0_instr = 32'h02328020;
      exp_q.push_back(32'h02328020);
      rsp_q.push_back(2'b00);
      tick();
      bus.req0_valid = 1'b0;
      check("t1_c1_inv", 32'(bus.core_in_valid), 32'h0);
      tick();
      check("t1_c2_inv", 32'(bus.core_in_valid), 32'h1);
      check("t1_c2_instr", bus.core_instruction, 32'h02328020);
      tick();
      check("t1_c3_inv", 32'(bus.core_in_valid), 32'h0);
      tick();
      check("t1_c4_rsp", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'h0);
      tick();
      check("t1_c5_rsp", 32'({bus.rsp1_valid, bus.rsp0_valid, bus.rsp0_fail}), 32'h2);
      tick();
      check("t1_c6_rsp", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'h0);
      wait_idle("t1_drain", 10);

      // 2: round-robin alternation, back-to-back
      do_reset();
      for (int i = 0; i < 3; i++) begin
         bus.req0_valid = 1'b1;
         bus.req0_instr = 32'hA000_0000 + 32'(i);
         bus.req1_valid = 1'b1;
         bus.req1_instr = 32'hB000_0000 + 32'(i);
         tick();
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(32'hA000_0000 + 32'(i));
         exp_q.push_back(32'hB000_0000 + 32'(i));
         rsp_q.push_back(2'b00);
         rsp_q.push_back(2'b10);
      end
      bus.issue_en = 1'b1;
      tick();
      for (int k = 0; k < 6; k++) begin
         check("t2_b2b", 32'(bus.core_in_valid), 32'h1);
         tick();
      end
      check("t2_stop", 32'(bus.core_in_valid), 32'h0);
      wait_idle("t2_drain", 20);

      // 3: full FIFO refuses, even in a popping cycle
      do_reset();
      for (int k = 0; k < 4; k++) begin
         bus.req0_valid = 1'b1;
         bus.req0_instr = 32'hC000_0000 + 32'(k);
         check("t3_ready_fill", 32'(bus.req0_ready), 32'h1);
         exp_q.push_back(32'hC000_0000 + 32'(k));
         rsp_q.push_back(2'b00);
         tick();
      end
      bus.req0_instr = 32'hC000_0004;
      check("t3_full", 32'(bus.req0_ready), 32'h0);
      tick();
      check("t3_refused", 32'(bus.req0_ready), 32'h0);
      bus.issue_en = 1'b1;
      check("t3_pop_cycle", 32'(bus.req0_ready), 32'h0);
      tick();
      bus.req0_valid = 1'b0;
      check("t3_ready_back", 32'(bus.req0_ready), 32'h1);
      wait_idle("t3_drain", 30);

      // 4: failures on requester 1, counter saturation at CNT_W=2
      do_reset();
      fail_mode    = 1'b1;
      bus.issue_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.req1_valid = 1'b1;
         bus.req1_instr = 32'hF000_0000 + 32'(k);
         exp_q.push_back(32'hF000_0000 + 32'(k));
         rsp_q.push_back(2'b11);
         tick();
      end
      bus.req1_valid = 1'b0;
      wait_idle("t4_drain_a", 20);
      check("t4_cnt1_3", 32'(bus.fail_cnt1), 32'h3);
      check("t4_cnt0_0", 32'(bus.fail_cnt0), 32'h0);
      for (int k = 3; k < 5; k++) begin
         bus.req1_valid = 1'b1;
         bus.req1_instr = 32'hF000_0000 + 32'(k);
         exp_q.push_back(32'hF000_0000 + 32'(k));
         rsp_q.push_back(2'b11);
         tick();
      end
      bus.req1_valid = 1'b0;
      wait_idle("t4_drain_b", 20);
      check("t4_cnt1_sat", 32'(bus.fail_cnt1), 32'h3);
      check("t4_cnt0_still", 32'(bus.fail_cnt0), 32'h0);

      // 5: flush with entries queued and one instruction in flight
      do_reset();
      for (int k = 0; k < 3; k++) begin
         bus.req0_valid = 1'b1;
         bus.req0_instr = 32'hD000_0000 + 32'(k);
         tick();
      end
      bus.req0_valid = 1'b0;
      exp_q.push_back(32'hD000_0000);
      rsp_q.push_back(2'b00);
      bus.issue_en = 1'b1;
      tick();
      check("t5_inflight", 32'(bus.core_in_valid), 32'h1);
      bus.flush      = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req0_instr = 32'hEEEE_0000;
      bus.req1_valid = 1'b1;
      bus.req1_instr = 32'hEEEE_0001;
      tick();
      bus.flush      = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      check("t5_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'h3);
      for (int k = 0; k < 5; k++) begin
         check("t5_no_issue", 32'(bus.core_in_valid), 32'h0);
         tick();
      end
      wait_idle("t5_drain", 10);

      // 6: orphan result -> sticky tag_err; async reset mid-stream
      do_reset();
      stray = 1'b1;
      tick();
      stray = 1'b0;
      check("t6_tag_err", 32'(bus.tag_err), 32'h1);
      repeat (3) tick();
      check("t6_tag_err_sticky", 32'(bus.tag_err), 32'h1);
      bus.issue_en = 1'b1;
      for (int k = 0; k < 2; k++) begin
         bus.req0_valid = 1'b1;
         bus.req0_instr = 32'h6000_0000 + 32'(k);
         bus.req1_valid = 1'b1;
         bus.req1_instr = 32'h6100_0000 + 32'(k);
         exp_q.push_back(32'h6000_0000 + 32'(k));
         exp_q.push_back(32'h6100_0000 + 32'(k));
         rsp_q.push_back(2'b00);
         rsp_q.push_back(2'b10);
         tick();
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      repeat (4) tick();
      #2 rst_n = 1'b0;
      #1 check_reset("t6_async");
      exp_q.delete();
      rsp_q.delete();
      bus.issue_en = 1'b0;
      repeat (4) tick();
      rst_n = 1'b1;
      repeat (4) tick();
      check_reset("t6_after");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
